// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  loader_pkg
//  Shared types and defaults for the UART program loader and its receiver.
//  Revision: 1.0
// ============================================================================
package loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_ADDR_WIDTH   = 8;
    localparam int LEN_WIDTH            = 16;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  uart_rx
//  8N1 receiver: one-cycle byte_valid_o or frame_err_o pulse per character.
//  Revision: 1.0
// ============================================================================
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule : uart_rx
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
//  uart_program_loader
//  Loads a length-prefixed, XOR-checksummed image from UART into imem.
//  Revision: 1.0
// ============================================================================
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_rx_i,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH+1)'(2 ** ADDR_WIDTH);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clock        (clock),
        .reset        (reset),
        .rx_i         (uart_rx_i),
        .byte_o       (w_rx_byte),
        .byte_valid_o (w_rx_valid),
        .frame_err_o  (w_rx_ferr)
    );

    loader_state_e         state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [1:0]            lane_q;
    logic [31:0]           word_q;
    logic [7:0]            xor_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
    logic                  load_error_q;
    logic [ADDR_WIDTH:0]   word_count_q;

    logic [LEN_WIDTH-1:0]  w_len_full;
    logic                  w_len_bad;
    logic [31:0]           w_word_full;
    logic [ADDR_WIDTH:0]   w_next_count;
    logic                  w_last_word;
    logic                  w_active;

    assign w_len_full   = {w_rx_byte, len_q[7:0]};
    assign w_len_bad    = (w_len_full == '0) || ({1'b0, w_len_full} > MAX_WORDS);
    assign w_word_full  = {w_rx_byte, word_q[31:8]};
    assign w_next_count = word_count_q + 1'b1;
    assign w_last_word  = ((LEN_WIDTH+1)'(w_next_count) == {1'b0, len_q});
    assign w_active     = (state_q != DONE) && (state_q != ERROR);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= HDR_LO;
            len_q        <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            xor_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if (w_rx_ferr && w_active) begin
                state_q      <= ERROR;
                load_error_q <= 1'b1;
            end else if (w_rx_valid) begin
                case (state_q)
                    HDR_LO: begin
                        len_q[7:0] <= w_rx_byte;
                        state_q    <= HDR_HI;
                    end
                    HDR_HI: begin
                        len_q[15:8] <= w_rx_byte;
                        lane_q      <= '0;
                        xor_q       <= '0;
                        if (w_len_bad) begin
                            state_q      <= ERROR;
                            load_error_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        // Words arrive little-endian, so each byte enters at the top.
                        word_q <= w_word_full;
                        xor_q  <= xor_q ^ w_rx_byte;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_count_q[ADDR_WIDTH-1:0];
                            imem_wdata_q <= w_word_full;
                            word_count_q <= w_next_count;
                            if (w_last_word) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (w_rx_byte == xor_q) begin
                            state_q     <= DONE;
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            state_q      <= ERROR;
                            load_error_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;

endmodule : uart_program_loader
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// ============================================================================
//  tb_uart_program_loader
//  Directed self-checking bench for the UART program loader.
//  Revision: 1.0
// ============================================================================
module tb_uart_program_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   word_count;

    int total  = 0;
    int passed = 0;

    logic [AW-1:0] log_addr [0:63];
    logic [31:0]   log_data [0:63];
    int            we_total = 0;
    int            base;

    uart_program_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .uart_rx_i  (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Every cycle with imem_we high is logged, so pulse counts double as width checks.
    always @(negedge clk) begin
        if (imem_we === 1'b1 && we_total < 64) begin
            log_addr[we_total] = imem_addr;
            log_data[we_total] = imem_wdata;
            we_total = we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset hold with idle line
        rx    = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we",    {31'd0, imem_we},    32'd0);
        check("rst_addr",  {28'd0, imem_addr},  32'd0);
        check("rst_wdata", imem_wdata,          32'd0);
        check("rst_hold",  {31'd0, cpu_hold},   32'd1);
        check("rst_done",  {31'd0, load_done},  32'd0);
        check("rst_err",   {31'd0, load_error}, 32'd0);
        check("rst_count", {27'd0, word_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Good load: payload bytes 93 00 50 00 13 81 10 00 XOR to 0x41
        base = we_total;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0050_0093);
        send_word(32'h0010_8113);
        check("good_hold_pre", {31'd0, cpu_hold},  32'd1);
        check("good_done_pre", {31'd0, load_done}, 32'd0);
        send_byte(8'h41, 1'b1);
        check("good_we_pulses", we_total - base, 32'd2);
        check("good_addr0", {28'd0, log_addr[base]},   32'd0);
        check("good_data0", log_data[base],            32'h0050_0093);
        check("good_addr1", {28'd0, log_addr[base+1]}, 32'd1);
        check("good_data1", log_data[base+1],          32'h0010_8113);
        check("good_done",  {31'd0, load_done},  32'd1);
        check("good_hold",  {31'd0, cpu_hold},   32'd0);
        check("good_err",   {31'd0, load_error}, 32'd0);
        check("good_count", {27'd0, word_count}, 32'd2);
        send_word(32'hDEAD_BEEF);
        check("good_ignore_we", we_total - base, 32'd2);

        // Bad checksum
        do_reset();
        base = we_total;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0050_0093);
        send_word(32'h0010_8113);
        send_byte(8'h53, 1'b1);
        check("badsum_we_pulses", we_total - base, 32'd2);
        check("badsum_err",  {31'd0, load_error}, 32'd1);
        check("badsum_hold", {31'd0, cpu_hold},   32'd1);
        check("badsum_done", {31'd0, load_done},  32'd0);

        // Length zero
        do_reset();
        base = we_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len0_err", {31'd0, load_error}, 32'd1);
        send_word(32'h1122_3344);
        check("len0_we", we_total - base, 32'd0);

        // Length one past the memory depth
        do_reset();
        base = we_total;
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len17_err", {31'd0, load_error}, 32'd1);
        send_word(32'h5566_7788);
        check("len17_we",    we_total - base, 32'd0);
        check("len17_count", {27'd0, word_count}, 32'd0);

        // Length equal to the memory depth is accepted
        do_reset();
        base = we_total;
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len16_err", {31'd0, load_error}, 32'd0);
        send_word(32'hCAFE_F00D);
        check("len16_count", {27'd0, word_count}, 32'd1);
        check("len16_data",  log_data[base],      32'hCAFE_F00D);

        // Framing error on third payload byte
        do_reset();
        base = we_total;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        check("ferr_err",   {31'd0, load_error}, 32'd1);
        check("ferr_count", {27'd0, word_count}, 32'd0);
        check("ferr_hold",  {31'd0, cpu_hold},   32'd1);
        check("ferr_we",    we_total - base,     32'd0);

        // Reset mid-load, one-cycle glitch, then a full good image
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hFFFF_FFFF);
        send_byte(8'h77, 1'b1);
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        base = we_total;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0050_0093);
        send_word(32'h0010_8113);
        send_byte(8'h41, 1'b1);
        check("mid_count", {27'd0, word_count}, 32'd2);
        check("mid_done",  {31'd0, load_done},  32'd1);
        check("mid_we",    we_total - base,     32'd2);
        check("mid_data0", log_data[base],      32'h0050_0093);
        check("mid_addr1", {28'd0, log_addr[base+1]}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_uart_program_loader
`default_nettype wire
